// File: rtl/bi_link.sv
// Registered, direction-switchable point-to-point link between two router ports.
// Optional even-parity protection of the held word is enabled with BI_LINK_PARITY_EN.
module bi_link #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inout_select1,
  input  logic              inout_select2,
  input  logic              in_valid1,
  input  logic [DATA_W-1:0] IN1,
  output logic [DATA_W-1:0] OUT1,
  output logic              out_valid1,
  input  logic              in_valid2,
  input  logic [DATA_W-1:0] IN2,
  output logic [DATA_W-1:0] OUT2,
  output logic              out_valid2,
`ifdef BI_LINK_PARITY_EN
  output logic              parity_err,
`endif
  output logic              conflict
);

  // state  | meaning
  // IDLE   | no direction owned; nothing delivered
  // D12    | end 1 transmits to end 2
  // D21    | end 2 transmits to end 1
  // CONF   | decode only: both ends transmitting (dir_q never holds it)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D12  = 2'd1,
    D21  = 2'd2,
    CONF = 2'd3
  } dir_t;

  dir_t              dec;
  dir_t              dir_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              conflict_q;

  always_comb begin
    dec = IDLE;
    case ({inout_select1, inout_select2})
      2'b01:   dec = D12;
      2'b10:   dec = D21;
      2'b11:   dec = IDLE;
      default: dec = CONF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      case (dec)
        CONF: begin
          valid_q    <= 1'b0;
          conflict_q <= 1'b1;
          dir_q      <= IDLE;
        end
        IDLE: begin
          valid_q    <= 1'b0;
          conflict_q <= 1'b0;
          dir_q      <= IDLE;
        end
        default: begin
          conflict_q <= 1'b0;
          if (dec != dir_q) begin
            // turnaround bubble: any word still held is dropped
            dir_q   <= dec;
            valid_q <= 1'b0;
          end else if (dec == D12) begin
            valid_q <= in_valid1;
            if (in_valid1) data_q <= IN1;
          end else begin
            valid_q <= in_valid2;
            if (in_valid2) data_q <= IN2;
          end
        end
      endcase
    end
  end

  assign out_valid2 = valid_q && (dir_q == D12);
  assign out_valid1 = valid_q && (dir_q == D21);
  assign OUT2       = out_valid2 ? data_q : '0;
  assign OUT1       = out_valid1 ? data_q : '0;
  assign conflict   = conflict_q;

`ifdef BI_LINK_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (dec == dir_q && dec == D12 && in_valid1) begin
      par_q <= ^IN1;
    end else if (dec == dir_q && dec == D21 && in_valid2) begin
      par_q <= ^IN2;
    end
  end

  assign parity_err = (out_valid1 || out_valid2) && ((^data_q) != par_q);
`endif

endmodule

// File: tb/tb_bi_link.sv
// Self-checking bench for bi_link: directed steps plus a random select/data walk
// checked against a history-based model of which words must be delivered where.
module tb_bi_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inout_select1 = 1'b1;
  logic        inout_select2 = 1'b1;
  logic        in_valid1 = 1'b0;
  logic [31:0] IN1 = '0;
  logic [31:0] OUT1;
  logic        out_valid1;
  logic        in_valid2 = 1'b0;
  logic [31:0] IN2 = '0;
  logic [31:0] OUT2;
  logic        out_valid2;
  logic        conflict;

  int total = 0;
  int bad = 0;

  // selection seen at the previous clock edge (11 = idle, also the post-reset history)
  logic [1:0] prev_sel = 2'b11;
  logic [1:0] rs = 2'b11;

  bi_link #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inout_select1(inout_select1), .inout_select2(inout_select2),
    .in_valid1(in_valid1), .IN1(IN1), .OUT1(OUT1), .out_valid1(out_valid1),
    .in_valid2(in_valid2), .IN2(IN2), .OUT2(OUT2), .out_valid2(out_valid2),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v1, input logic [31:0] o1,
                         input logic v2, input logic [31:0] o2, input logic c);
    chk({tag, ".out_valid1"}, {31'd0, out_valid1}, {31'd0, v1});
    chk({tag, ".OUT1"}, OUT1, o1);
    chk({tag, ".out_valid2"}, {31'd0, out_valid2}, {31'd0, v2});
    chk({tag, ".OUT2"}, OUT2, o2);
    chk({tag, ".conflict"}, {31'd0, conflict}, {31'd0, c});
  endtask

  // A word reaches the far end only when the same transfer direction was selected
  // at this edge and the one before it; the word is whatever was offered at this edge.
  task automatic step(input string tag, input logic s1, input logic s2,
                      input logic v1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] d2);
    logic [1:0] cur;
    logic ev1, ev2, ec;
    logic [31:0] eo1, eo2;
    inout_select1 = s1; inout_select2 = s2;
    in_valid1 = v1; IN1 = d1; in_valid2 = v2; IN2 = d2;
    cur = {s1, s2};
    ec  = (cur == 2'b00);
    ev2 = (cur == 2'b01) && (prev_sel == 2'b01) && v1;
    ev1 = (cur == 2'b10) && (prev_sel == 2'b10) && v2;
    eo2 = ev2 ? d1 : 32'd0;
    eo1 = ev1 ? d2 : 32'd0;
    @(posedge clk);
    #1;
    chk_all(tag, ev1, eo1, ev2, eo2, ec);
    prev_sel = cur;
  endtask

  initial begin
    // reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    prev_sel = 2'b11;

    // reset then D12: edge 1 bubble, edge 2 delivers
    step("d12_bubble", 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 32'h2);
    step("d12_first",  1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 32'h2);

    // stream A, B, C back to back
    step("stream_a", 1'b0, 1'b1, 1'b1, 32'hA, 1'b1, 32'h5);
    step("stream_b", 1'b0, 1'b1, 1'b1, 32'hB, 1'b1, 32'h6);
    step("stream_c", 1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h7);

    // reversal: one bubble, then end 1 receives
    step("rev_bubble", 1'b1, 1'b0, 1'b1, 32'h9, 1'b1, 32'h2);
    step("rev_first",  1'b1, 1'b0, 1'b1, 32'h9, 1'b1, 32'h2);

    // conflict for 3 cycles then back to D12 with a bubble
    repeat (3) step("conflict", 1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 32'h44);
    step("post_conf_bubble", 1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 32'h0);
    step("post_conf_first",  1'b0, 1'b1, 1'b1, 32'h56, 1'b0, 32'h0);

    // idle with in_valid1, then D12 with in_valid1 low
    step("idle", 1'b1, 1'b1, 1'b1, 32'h77, 1'b1, 32'h88);
    step("d12_bubble2", 1'b0, 1'b1, 1'b0, 32'h78, 1'b0, 32'h0);
    step("d12_invalid", 1'b0, 1'b1, 1'b0, 32'h79, 1'b1, 32'h99);

    // random walk: selects mostly held to exercise streaming, sometimes switched
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) rs = 2'($urandom_range(0, 3));
      step("random", rs[1], rs[0], 1'($urandom_range(0, 1)), $urandom(),
           1'($urandom_range(0, 1)), $urandom());
    end

    // asynchronous reset between edges while end 2 is receiving
    step("ar_bubble", 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step("ar_active", 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bi_link.md
Name: bi_link

Overview:
- Registered, direction-switchable point-to-point channel between two BiNoC router ports (end 1 and end 2).
- Each end declares itself transmitter or receiver through its select line.
- One word per cycle moves from the transmitting end to the receiving end with one-cycle latency.
- A direction change inserts one turnaround bubble; both ends transmitting is flagged as a conflict.

Parameters:
DATA_W, 32, flit/data width in bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
inout_select1  input  1  end-1 role: 0 = transmit, 1 = receive.
inout_select2  input  1  end-2 role: 0 = transmit, 1 = receive.
in_valid1  input  1  IN1 holds a valid word.
IN1  input  DATA_W  data offered by end 1.
OUT1  output  DATA_W  data delivered to end 1.
out_valid1  output  1  OUT1 valid.
in_valid2  input  1  IN2 holds a valid word.
IN2  input  DATA_W  data offered by end 2.
OUT2  output  DATA_W  data delivered to end 2.
out_valid2  output  1  OUT2 valid.
conflict  output  1  registered; both ends selected transmit.
parity_err  output  1  only with BI_LINK_PARITY_EN; see below.

Behaviour:
- Combinational direction decode from {inout_select1, inout_select2}:
  - 01 = D12 (end 1 to end 2)
  - 10 = D21
  - 11 = IDLE
  - 00 = CONFLICT
- State registers:
  - dir_q in {IDLE, D12, D21}
  - data_q[DATA_W-1:0]
  - valid_q
  - conflict_q
- Reset (rst_n low, asynchronous): dir_q=IDLE, data_q=0, valid_q=0, conflict_q=0. All outputs read 0 during reset.
- Each rising edge, in priority order:
  1. Decode CONFLICT: valid_q<=0, conflict_q<=1, dir_q<=IDLE, data_q held.
  2. Decode IDLE: valid_q<=0, conflict_q<=0, dir_q<=IDLE.
  3. Decode D12/D21 differing from dir_q (turnaround): dir_q<=decode, valid_q<=0, no capture, conflict_q<=0.
  4. Decode D12 equal to dir_q: valid_q<=in_valid1. If in_valid1=1, data_q<=IN1.
  5. Decode D21 equal to dir_q: valid_q<=in_valid2. If in_valid2=1, data_q<=IN2.
- Outputs (combinational from registers only; no input-to-output path):
  - out_valid2 = valid_q & (dir_q==D12); OUT2 = out_valid2 ? data_q : 0.
  - out_valid1 = valid_q & (dir_q==D21); OUT1 = out_valid1 ? data_q : 0.
  - conflict = conflict_q.
- Latency:
  - Word accepted at edge N appears at edge N+1's output window (1 cycle).
  - After reset or any direction change, the first word is captured one edge later (turnaround bubble).
  - Steady-state throughput 1 word/cycle.
- Select change mid-transfer: an in-flight word in data_q is dropped (valid_q cleared); no word is ever delivered to the end that supplied it.
- in_valid on a receiving end is ignored.

Optional Feature:
BI_LINK_PARITY_EN:
- Defined:
  - Link carries an extra even-parity bit par_q, registered alongside data_q and computed as XOR of the captured IN word.
  - Receiver side recomputes parity of data_q each cycle.
  - parity_err = out_valid (either end) & (recomputed != par_q). It can only assert under fault injection; it stays 0 in normal operation.
  - Reset clears par_q.
- Undefined: par_q and parity_err logic absent; the parity_err port does not exist.

Test Plan:
- Reset then D12:
  - Stimulus: rst_n low 2 cycles; release with sel1=0, sel2=1, in_valid1=1, IN1=32'h1, IN2=32'h2.
  - Edge 1 is turnaround. Edge 2: OUT2=32'h1, out_valid2=1, OUT1=0, out_valid1=0.
- Stream:
  - Stimulus: D12 steady; IN1 = 32'hA, 32'hB, 32'hC on consecutive cycles.
  - OUT2 shows A, B, C on the following consecutive cycles with no gaps.
- Reversal:
  - Stimulus: after a D12 word, switch to sel1=1, sel2=0 with IN2=32'h2, in_valid2=1.
  - One bubble cycle with both out_valid=0, then OUT1=32'h2, out_valid1=1.
- Conflict:
  - Stimulus: sel1=sel2=0 for 3 cycles.
  - conflict=1 from the next edge; out_valid1 and out_valid2 both 0. Returning to 01 gives conflict=0 plus one turnaround bubble.
- Idle and invalid:
  - Stimulus: sel=11 with in_valid1=1; then D12 with in_valid1=0.
  - No output valid in either case; OUT1 and OUT2 read 0.
- Asynchronous reset mid-stream:
  - Stimulus: pull rst_n low between clock edges while out_valid2=1.
  - out_valid2 and OUT2 go 0 immediately, without waiting for a clock edge.
